cp0_timer_ctrl: RTL and testbench

- Next-generation coprocessor-0 for the pipelined MIPS core.
- Parametrised number of external interrupt lines, plus two software interrupt bits and a Count/Compare timer interrupt.
- Adds a BadVAddr register and a masked register-write map.
- Sits beside the M stage: takes exception info and the victim PC, drives the redirect request and EPC to the fetch stage.

---
 rtl/cp0_pkg.sv | 34 +++
 rtl/cp0_timer_ctrl_if.sv | 28 ++
 rtl/cp0_count_timer.sv | 44 ++++
 rtl/cp0_timer_ctrl.sv | 123 ++++++++++++
 tb/tb_cp0_timer_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// CP0 register numbers, exception codes and Status/Cause field layout shared by the CP0 block.
// Pure definitions; no logic or timing of its own.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE      = 0;
    localparam int SR_EXL     = 1;
    localparam int SR_IM_LO   = 8;
    localparam int SR_IM_HI   = 15;
    localparam int CAUSE_SW_LO = 8;
    localparam int CAUSE_SW_HI = 9;

    localparam logic [31:0] SR_WMASK    = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK = 32'h0000_0300;

    // Only address-error exceptions capture the faulting address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer_ctrl_if.sv
// M-stage <-> CP0 signal bundle: mtc0/mfc0 access, exception info in, redirect request and EPC out.
// master = pipeline side, slave = CP0 side; no handshake, all signals are per-cycle.
interface cp0_timer_ctrl_if #(
    parameter int NUM_HWINT = 5
);
    logic                 we;
    logic [4:0]           addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic [31:0]          vpc;
    logic                 bd_in;
    logic [4:0]           exc_code_in;
    logic [31:0]          bad_vaddr_in;
    logic [NUM_HWINT-1:0] hw_int;
    logic                 eret;
    logic                 req;
    logic [31:0]          epc_out;

    modport master (
        output we, addr, wdata, vpc, bd_in, exc_code_in, bad_vaddr_in, hw_int, eret,
        input  rdata, req, epc_out
    );

    modport slave (
        input  we, addr, wdata, vpc, bd_in, exc_code_in, bad_vaddr_in, hw_int, eret,
        output rdata, req, epc_out
    );
endinterface

// File: rtl/cp0_count_timer.sv
// Free-running Count with Compare match raising a sticky TI; writes load the next-cycle value.
// TI rises on the edge where Count becomes equal to Compare; writing Compare clears it.
module cp0_count_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti
);
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = we_count ? wdata : count_q + 32'd1;
        compare_d = we_compare ? wdata : compare_q;
        // A Compare write acknowledges the interrupt even if the match lands this same cycle.
        if (we_compare)
            ti_d = 1'b0;
        else if (count_d == compare_q)
            ti_d = 1'b1;
        else
            ti_d = ti_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti        = ti_q;
endmodule

// File: rtl/cp0_timer_ctrl.sv
// Coprocessor 0: Status/Cause/EPC/BadVAddr, Count/Compare timer and interrupt/exception request.
// req and rdata are combinational; register side effects appear the cycle after the edge.
module cp0_timer_ctrl #(
    parameter int          NUM_HWINT  = 5,
    parameter logic [31:0] PRID_VALUE = 32'h0000_4350,
    parameter logic [31:0] ERR_CODE   = 32'hFFFF_FFFF
) (
    input logic              clk,
    input logic              reset,
    cp0_timer_ctrl_if.slave  bus
);
    import cp0_pkg::*;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  ip_hw_q;
    logic        ip_ti_q;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [4:0]  hw_ext;
    logic [7:0]  pend;
    logic        int_req, exc_req, req;

    cp0_count_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .we_count   (bus.we && (bus.addr == CP0_COUNT)),
        .we_compare (bus.we && (bus.addr == CP0_COMPARE)),
        .wdata      (bus.wdata),
        .count_o    (count),
        .compare_o  (compare),
        .ti         (ti)
    );

    // Pending interrupts use the live lines, not the IP copy, so req is same-cycle.
    assign hw_ext  = 5'(bus.hw_int);
    assign pend    = {ti, hw_ext, ip_sw_q};
    assign int_req = ie_q & ~exl_q & (|(pend & im_q));
    assign exc_req = |bus.exc_code_in;
    assign req     = int_req | exc_req;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (req) begin
            exc_code_d = exc_req ? bus.exc_code_in : EXC_INT;
            bd_d       = bus.bd_in;
            epc_d      = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
            exl_d      = 1'b1;
            if (is_addr_exc(bus.exc_code_in))
                badvaddr_d = bus.bad_vaddr_in;
        end else if (bus.eret) begin
            exl_d = 1'b0;
        end else if (bus.we) begin
            case (bus.addr)
                CP0_SR: begin
                    im_d  = bus.wdata[SR_IM_HI:SR_IM_LO];
                    exl_d = bus.wdata[SR_EXL];
                    ie_d  = bus.wdata[SR_IE];
                end
                CP0_CAUSE: ip_sw_d = bus.wdata[CAUSE_SW_HI:CAUSE_SW_LO];
                CP0_EPC:   epc_d   = bus.wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            ip_ti_q    <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= hw_ext;
            ip_ti_q    <= ti;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        case (bus.addr)
            CP0_BADVADDR: bus.rdata = badvaddr_q;
            CP0_COUNT:    bus.rdata = count;
            CP0_COMPARE:  bus.rdata = compare;
            CP0_SR:       bus.rdata = {16'b0, im_q, 6'b0, exl_q, ie_q} & SR_WMASK;
            CP0_CAUSE:    bus.rdata = {bd_q, ti, 14'b0, ip_ti_q, ip_hw_q, ip_sw_q,
                                       1'b0, exc_code_q, 2'b0};
            CP0_EPC:      bus.rdata = epc_q;
            CP0_PRID:     bus.rdata = PRID_VALUE;
            default:      bus.rdata = ERR_CODE;
        endcase
    end

    assign bus.req     = req;
    assign bus.epc_out = epc_q;
endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Directed-vector bench for cp0_timer_ctrl: one table row per clock, plus hand sequences for wrap and reset.
module tb_cp0_timer_ctrl;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    cp0_timer_ctrl_if #(.NUM_HWINT(5)) bus ();

    cp0_timer_ctrl #(
        .NUM_HWINT  (5),
        .PRID_VALUE (32'h0000_4350),
        .ERR_CODE   (32'hFFFF_FFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] bva;
        logic [4:0]  hw;
        logic        eret;
        logic [31:0] exp_rdata;
        logic        exp_req;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                               input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                               input logic [31:0] bva, input logic [4:0] hw, input logic eret,
                               input logic [31:0] er, input logic eq, input logic [31:0] ee);
        vec_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.vpc = vpc; r.bd = bd; r.exc = exc;
        r.bva = bva; r.hw = hw; r.eret = eret; r.exp_rdata = er; r.exp_req = eq; r.exp_epc = ee;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                         input logic [31:0] bva, input logic [4:0] hw, input logic eret);
        bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.vpc = vpc; bus.bd_in = bd;
        bus.exc_code_in = exc; bus.bad_vaddr_in = bva; bus.hw_int = hw; bus.eret = eret;
    endtask

    task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp);
        bus.addr = addr;
        #1;
        chk(name, bus.rdata, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        // we addr wdata vpc bd exc bva hw eret | rdata req epc
        vecs.push_back(v(0, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(v(0, 9, 0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 0));
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(v(0, 14, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(v(0, 15, 0, 0, 0, 0, 0, 0, 0, 32'h0000_4350, 0, 0));
        vecs.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(v(0, 8, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(v(0, 11, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        // hw interrupt taken in a delay slot
        vecs.push_back(v(1, 12, 32'h401, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(v(0, 12, 0, 32'h3000, 1, 0, 0, 5'h01, 0, 32'h401, 1, 0));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 5'h01, 0, 32'h8000_0400, 0, 32'h2FFC));
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 5'h01, 0, 32'h403, 0, 32'h2FFC));
        // nested AdEL with concurrent eret
        vecs.push_back(v(0, 8, 0, 32'h3008, 0, 4, 32'h1001, 5'h01, 1, 32'h0, 1, 32'h2FFC));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h410, 0, 32'h3008));
        vecs.push_back(v(0, 8, 0, 0, 0, 0, 0, 0, 0, 32'h1001, 0, 32'h3008));
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h403, 0, 32'h3008));
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 0, 1, 32'h403, 0, 32'h3008));
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h401, 0, 32'h3008));
        // timer interrupt
        vecs.push_back(v(1, 11, 32'h10, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h3008));
        vecs.push_back(v(1, 9, 32'h0C, 0, 0, 0, 0, 0, 0, 32'h14, 0, 32'h3008));
        vecs.push_back(v(1, 12, 32'h8001, 0, 0, 0, 0, 0, 0, 32'h401, 0, 32'h3008));
        vecs.push_back(v(0, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0D, 0, 32'h3008));
        vecs.push_back(v(0, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0E, 0, 32'h3008));
        vecs.push_back(v(0, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0F, 0, 32'h3008));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h4000_0010, 1, 32'h3008));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h4000_8000, 0, 0));
        vecs.push_back(v(1, 11, 32'h100, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h8000, 0, 0));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        // software interrupt and write priority
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 0, 1, 32'h8003, 0, 0));
        vecs.push_back(v(1, 12, 32'h101, 0, 0, 0, 0, 0, 0, 32'h8001, 0, 0));
        vecs.push_back(v(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(v(0, 13, 0, 32'h4000, 0, 0, 0, 0, 0, 32'h300, 1, 0));
        vecs.push_back(v(1, 14, 32'hDEAD, 0, 0, 0, 0, 0, 1, 32'h4000, 0, 32'h4000));
        vecs.push_back(v(1, 12, 32'h0, 32'h5000, 0, 0, 0, 0, 0, 32'h101, 1, 32'h4000));
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h103, 0, 32'h5000));
        vecs.push_back(v(1, 13, 32'h0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 32'h5000));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h5000));
        vecs.push_back(v(0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h101, 0, 32'h5000));
        vecs.push_back(v(1, 14, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 32'h5000, 0, 32'h5000));
        vecs.push_back(v(0, 14, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 32'h1234_5678));
        // read-only BadVAddr; RI in delay slot leaves BadVAddr alone
        vecs.push_back(v(1, 8, 32'hAAAA, 0, 0, 0, 0, 0, 0, 32'h1001, 0, 32'h1234_5678));
        vecs.push_back(v(0, 8, 0, 0, 0, 0, 0, 0, 0, 32'h1001, 0, 32'h1234_5678));
        vecs.push_back(v(0, 8, 0, 32'h6004, 1, 10, 32'h7777, 0, 0, 32'h1001, 1, 32'h1234_5678));
        vecs.push_back(v(0, 8, 0, 0, 0, 0, 0, 0, 0, 32'h1001, 0, 32'h6000));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0028, 0, 32'h6000));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 5'h10, 0, 32'h8000_0028, 0, 32'h6000));
        vecs.push_back(v(0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h8000_4028, 0, 32'h6000));

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].vpc, vecs[i].bd,
                  vecs[i].exc, vecs[i].bva, vecs[i].hw, vecs[i].eret);
            @(negedge clk);
            chk($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_req", i), {31'b0, bus.req}, {31'b0, vecs[i].exp_req});
            chk($sformatf("v%0d_epc", i), bus.epc_out, vecs[i].exp_epc);
            @(posedge clk);
            #1;
        end

        // Count wrap with Compare=0: match on the wrap edge sets TI
        drive(1, 11, 32'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cmp_before_zero", bus.rdata, 32'h100);
        @(posedge clk); #1;
        drive(1, 9, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 9, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_fffffffe", bus.rdata, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_ffffffff", bus.rdata, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_zero", bus.rdata, 32'h0);
        @(posedge clk); #1;
        bus.addr = 13;
        @(negedge clk);
        chk("wrap_ti_cause", bus.rdata, 32'hC000_8028);
        chk("wrap_req_masked", {31'b0, bus.req}, 32'h0);
        @(posedge clk); #1;

        // Reset mid-operation with a hw line held high
        reset = 1'b1;
        bus.hw_int = 5'h01;
        @(posedge clk); #1;
        reset = 1'b0;
        rd("rst_count", 9, 32'h0);
        rd("rst_cause", 13, 32'h0);
        rd("rst_sr", 12, 32'h0);
        rd("rst_badvaddr", 8, 32'h0);
        chk("rst_epc", bus.epc_out, 32'h0);
        chk("rst_req", {31'b0, bus.req}, 32'h0);
        @(posedge clk); #1;
        rd("post_rst_cause_ip", 13, 32'h0000_0400);
        rd("post_rst_count", 9, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
